avf_occupancy_monitor: RTL and testbench



---
 rtl/avf_occupancy_monitor.sv | 154 +++++++++++++++
 tb/tb_avf_occupancy_monitor.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avf_occupancy_monitor.sv
// Live vulnerable-bit occupancy tracker with windowed ACE-bit-cycle integration and a hysteretic flag.
// Optional peak tracker is enabled by defining AVF_MON_PEAK_EN.
module avf_occupancy_monitor #(
   parameter int ALLOC_PORTS   = 4,
   parameter int DEALLOC_PORTS = 4,
   parameter int VBIT_W        = 8,
   parameter int RES_W         = 16,
   parameter int ACC_W         = 32,
   parameter int WIN_LOG2      = 10
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable_i,
   input  logic [ALLOC_PORTS-1:0]           alloc_valid_i,
   input  logic [ALLOC_PORTS*VBIT_W-1:0]    alloc_vbit_i,
   input  logic [DEALLOC_PORTS-1:0]         dealloc_valid_i,
   input  logic [DEALLOC_PORTS*VBIT_W-1:0]  dealloc_vbit_i,
   input  logic                             flush_i,
   input  logic [ACC_W-1:0]                 thresh_hi_i,
   input  logic [ACC_W-1:0]                 thresh_lo_i,
   output logic [RES_W-1:0]                 resident_o,
   output logic [ACC_W-1:0]                 window_acc_o,
   output logic                             window_valid_o,
   output logic                             high_vuln_o,
   output logic                             underflow_o,
`ifdef AVF_MON_PEAK_EN
   output logic [RES_W-1:0]                 peak_o,
`endif
   output logic                             dbg_state_o
);

   localparam int SUM_W = RES_W + 4;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                   state, state_nx;
   logic [WIN_LOG2-1:0]      cnt;
   logic [ACC_W-1:0]         acc;
   logic signed [SUM_W-1:0]  res_sum;
   logic [RES_W-1:0]         res_nx;
   logic                     uf_set;
   logic [ACC_W:0]           acc_sum;
   logic [ACC_W-1:0]         acc_sat;
   logic                     run_cycle;
   logic                     win_close;
   logic                     flag_nx;

   assign dbg_state_o = (state == RUN);
   assign run_cycle   = (state == RUN) && enable_i;
   assign win_close   = run_cycle && (cnt == {WIN_LOG2{1'b1}});

   // Signed net change at RES_W+4 bits so both saturation and underflow are visible.
   always_comb begin
      res_sum = $signed({4'b0000, resident_o});
      for (int p = 0; p < ALLOC_PORTS; p++) begin
         if (alloc_valid_i[p])
            res_sum = res_sum + $signed({{(SUM_W-VBIT_W){1'b0}}, alloc_vbit_i[p*VBIT_W +: VBIT_W]});
      end
      for (int p = 0; p < DEALLOC_PORTS; p++) begin
         if (dealloc_valid_i[p])
            res_sum = res_sum - $signed({{(SUM_W-VBIT_W){1'b0}}, dealloc_vbit_i[p*VBIT_W +: VBIT_W]});
      end
   end

   always_comb begin
      res_nx = res_sum[RES_W-1:0];
      uf_set = 1'b0;
      if (flush_i) begin
         res_nx = '0;
      end else if (res_sum < 0) begin
         res_nx = '0;
         uf_set = 1'b1;
      end else if (res_sum > $signed({4'b0000, {RES_W{1'b1}}})) begin
         res_nx = {RES_W{1'b1}};
      end
   end

   always_comb begin
      acc_sum = {1'b0, acc} + {{(ACC_W-RES_W+1){1'b0}}, resident_o};
      acc_sat = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
   end

   // Set wins over clear when the thresholds are inverted.
   always_comb begin
      flag_nx = high_vuln_o;
      if (acc_sat > thresh_hi_i)
         flag_nx = 1'b1;
      else if (acc_sat < thresh_lo_i)
         flag_nx = 1'b0;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable_i)  state_nx = RUN;
         RUN:     if (!enable_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         acc            <= '0;
         resident_o     <= '0;
         window_acc_o   <= '0;
         window_valid_o <= 1'b0;
         high_vuln_o    <= 1'b0;
         underflow_o    <= 1'b0;
      end else begin
         state          <= state_nx;
         resident_o     <= res_nx;
         window_valid_o <= win_close;
         if (uf_set)
            underflow_o <= 1'b1;
         if (!run_cycle) begin
            cnt <= '0;
            acc <= '0;
         end else if (win_close) begin
            window_acc_o <= acc_sat;
            high_vuln_o  <= flag_nx;
            cnt          <= '0;
            acc          <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            acc <= acc_sat;
         end
      end
   end

`ifdef AVF_MON_PEAK_EN
   logic [RES_W-1:0] peak_trk;
   logic [RES_W-1:0] peak_max;

   assign peak_max = (resident_o > peak_trk) ? resident_o : peak_trk;

   // The tracker restarts from the value that will be the next window's first sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         peak_trk <= '0;
         peak_o   <= '0;
      end else if (!run_cycle) begin
         peak_trk <= res_nx;
      end else if (win_close) begin
         peak_o   <= peak_max;
         peak_trk <= res_nx;
      end else begin
         peak_trk <= peak_max;
      end
   end
`endif

endmodule

// File: tb/tb_avf_occupancy_monitor.sv
// Self-checking bench for avf_occupancy_monitor with short windows (WIN_LOG2=4) and a
// behavioural model that keeps each window's resident samples in a queue.
module tb_avf_occupancy_monitor;

   localparam int AP  = 4;
   localparam int DP  = 4;
   localparam int VW  = 8;
   localparam int RW  = 16;
   localparam int AW  = 32;
   localparam int WL  = 4;
   localparam int WIN = 1 << WL;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable_i;
   logic [AP-1:0]  alloc_valid_i;
   logic [AP*VW-1:0] alloc_vbit_i;
   logic [DP-1:0]  dealloc_valid_i;
   logic [DP*VW-1:0] dealloc_vbit_i;
   logic           flush_i;
   logic [AW-1:0]  thresh_hi_i;
   logic [AW-1:0]  thresh_lo_i;
   logic [RW-1:0]  resident_o;
   logic [AW-1:0]  window_acc_o;
   logic           window_valid_o;
   logic           high_vuln_o;
   logic           underflow_o;
   logic           dbg_state_o;
`ifdef AVF_MON_PEAK_EN
   logic [RW-1:0]  peak_o;
`endif

   avf_occupancy_monitor #(
      .ALLOC_PORTS(AP), .DEALLOC_PORTS(DP), .VBIT_W(VW),
      .RES_W(RW), .ACC_W(AW), .WIN_LOG2(WL)
   ) dut (
      .clk(clk), .reset(reset), .enable_i(enable_i),
      .alloc_valid_i(alloc_valid_i), .alloc_vbit_i(alloc_vbit_i),
      .dealloc_valid_i(dealloc_valid_i), .dealloc_vbit_i(dealloc_vbit_i),
      .flush_i(flush_i), .thresh_hi_i(thresh_hi_i), .thresh_lo_i(thresh_lo_i),
      .resident_o(resident_o), .window_acc_o(window_acc_o),
      .window_valid_o(window_valid_o), .high_vuln_o(high_vuln_o),
      .underflow_o(underflow_o),
`ifdef AVF_MON_PEAK_EN
      .peak_o(peak_o),
`endif
      .dbg_state_o(dbg_state_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // reference model state
   longint          res_m;
   bit              uf_m, run_m, vld_m, flag_m;
   longint          win_m;
   longint          win_q[$];
   logic [AW-1:0]   exp_q[$];

   task automatic model_edge();
      longint s;
      vld_m = 1'b0;
      if (reset) begin
         res_m = 0; uf_m = 0; run_m = 0; win_m = 0; flag_m = 0;
         win_q.delete();
         exp_q.delete();
         return;
      end
      if (run_m) begin
         if (enable_i) begin
            win_q.push_back(res_m);
            if (win_q.size() == WIN) begin
               s = 0;
               foreach (win_q[i]) s += win_q[i];
               if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
               win_m = s;
               vld_m = 1'b1;
               if (s > longint'(thresh_hi_i))      flag_m = 1'b1;
               else if (s < longint'(thresh_lo_i)) flag_m = 1'b0;
               exp_q.push_back(AW'(s));
               win_q.delete();
            end
         end else begin
            run_m = 0;
            win_q.delete();
         end
      end else if (enable_i) begin
         run_m = 1;
         win_q.delete();
      end
      if (flush_i) begin
         res_m = 0;
      end else begin
         s = res_m;
         for (int p = 0; p < AP; p++)
            if (alloc_valid_i[p]) s += alloc_vbit_i[p*VW +: VW];
         for (int p = 0; p < DP; p++)
            if (dealloc_valid_i[p]) s -= dealloc_vbit_i[p*VW +: VW];
         if (s < 0) begin
            s = 0;
            uf_m = 1;
         end else if (s > 65535) begin
            s = 65535;
         end
         res_m = s;
      end
   endtask

   task automatic compare();
      logic [AW-1:0] e;
      check("resident", resident_o, res_m[31:0]);
      check("underflow", underflow_o, uf_m);
      check("win_valid", window_valid_o, vld_m);
      check("win_acc", window_acc_o, win_m[31:0]);
      check("high_vuln", high_vuln_o, flag_m);
      check("state", dbg_state_o, run_m);
      if (window_valid_o) begin
         if (exp_q.size() == 0) begin
            check("win_q_empty", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("win_q", window_acc_o, e);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   // driver tasks
   task automatic idle_strobes();
      alloc_valid_i = '0; alloc_vbit_i = '0;
      dealloc_valid_i = '0; dealloc_vbit_i = '0;
      flush_i = 1'b0;
   endtask

   task automatic alloc(input int p, input int v);
      alloc_valid_i[p] = 1'b1;
      alloc_vbit_i[p*VW +: VW] = VW'(v);
   endtask

   task automatic dealloc(input int p, input int v);
      dealloc_valid_i[p] = 1'b1;
      dealloc_vbit_i[p*VW +: VW] = VW'(v);
   endtask

   task automatic preload(input longint target);
      longint d;
      for (int k = 0; k < 400 && res_m != target; k++) begin
         idle_strobes();
         if (res_m < target) begin
            d = target - res_m;
            for (int p = 0; p < AP && d > 0; p++) begin
               alloc(p, (d > 255) ? 255 : int'(d));
               d -= (d > 255) ? 255 : d;
            end
         end else begin
            d = res_m - target;
            dealloc(0, (d > 255) ? 255 : int'(d));
         end
         cycle();
      end
      idle_strobes();
      check("preload", resident_o, target[31:0]);
   endtask

   task automatic wait_pulse(output int n);
      bit seen = 0;
      n = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         cycle();
         n++;
         if (window_valid_o) seen = 1;
      end
      if (!seen) check("pulse_timeout", 0, 1);
   endtask

   int n, pulses;
   int hv_r[3]   = '{56, 38, 19};
   int hv_tot[3] = '{896, 608, 304};
   int hv_f[3]   = '{1, 1, 0};

   initial begin
      reset = 1'b1; enable_i = 1'b0;
      thresh_hi_i = 700; thresh_lo_i = 300;
      idle_strobes();

      // reset with strobes active
      for (int p = 0; p < AP; p++) alloc(p, 9);
      dealloc(1, 3);
      enable_i = 1'b1;
      cycle();
      cycle();
      check("rst_res", resident_o, 0);
      check("rst_state", dbg_state_o, 0);
      reset = 1'b0; enable_i = 1'b0;
      idle_strobes();
      cycle();
      check("post_rst_res", resident_o, 0);

      // first window: resident 50 over 16 RUN cycles
      preload(50);
      enable_i = 1'b1;
      wait_pulse(n);
      check("win_latency", n, WIN + 1);
      check("win800", window_acc_o, 800);
      check("hv_800", high_vuln_o, 1);
      enable_i = 1'b0;
      cycle();

      // hysteresis sequence
      thresh_hi_i = 800; thresh_lo_i = 400;
      for (int i = 0; i < 3; i++) begin
         preload(hv_r[i]);
         enable_i = 1'b1;
         wait_pulse(n);
         check("hv_total", window_acc_o, hv_tot[i]);
         check("hv_flag", high_vuln_o, hv_f[i]);
         enable_i = 1'b0;
         cycle();
      end

      // enable dropped mid-window
      enable_i = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin cycle(); pulses += window_valid_o; end
      enable_i = 1'b0;
      for (int k = 0; k < 20; k++) begin cycle(); pulses += window_valid_o; end
      check("no_pulse", pulses, 0);

      // mixed alloc/dealloc in one cycle
      preload(100);
      for (int p = 0; p < AP; p++) alloc(p, 66);
      dealloc(0, 94); dealloc(2, 94);
      cycle();
      idle_strobes();
      check("mix176", resident_o, 176);
      check("mix_uf", underflow_o, 0);

      // underflow is sticky
      preload(10);
      dealloc(3, 30);
      cycle();
      idle_strobes();
      check("uf_res", resident_o, 0);
      check("uf_set", underflow_o, 1);
      for (int k = 0; k < 20; k++) cycle();
      check("uf_sticky", underflow_o, 1);

      // flush beats same-cycle alloc; saturation at top
      preload(500);
      flush_i = 1'b1; alloc(1, 23);
      cycle();
      idle_strobes();
      check("flush", resident_o, 0);
      preload(65530);
      for (int p = 0; p < AP; p++) alloc(p, 8);
      cycle();
      idle_strobes();
      check("sat", resident_o, 65535);

      // randomized phase from a fresh reset
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      thresh_hi_i = $urandom_range(1500, 5000);
      thresh_lo_i = $urandom_range(500, 5000);
      for (int k = 0; k < 900; k++) begin
         idle_strobes();
         for (int p = 0; p < AP; p++)
            if ($urandom_range(0, 1)) alloc(p, $urandom_range(0, 60));
         for (int p = 0; p < DP; p++)
            if ($urandom_range(0, 1)) dealloc(p, $urandom_range(0, 50));
         flush_i = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 99) == 0) enable_i = ~enable_i;
         else if (k < 5) enable_i = 1'b1;
         if ($urandom_range(0, 199) == 0) begin
            thresh_hi_i = $urandom_range(1500, 5000);
            thresh_lo_i = $urandom_range(500, 5000);
         end
         cycle();
      end
      idle_strobes();
      enable_i = 1'b0;
      cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
